// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache client ports and the memory port served by mem_arbiter.
// Handshake: cN_req is held by the client until cN_done; cN_accept/cN_done are one-cycle pulses; mem_is_input_valid holds until mem_ready.
interface mem_arbiter_if #(
    parameter int LINE_SIZE = 16,
    parameter int ADDR_W    = 32
);
    localparam int DW = LINE_SIZE * 8;

    logic              c0_req;
    logic              c0_write;
    logic [ADDR_W-1:0] c0_addr;
    logic [DW-1:0]     c0_din;
    logic              c0_accept;
    logic              c0_done;
    logic [DW-1:0]     c0_dout;

    logic              c1_req;
    logic              c1_write;
    logic [ADDR_W-1:0] c1_addr;
    logic [DW-1:0]     c1_din;
    logic              c1_accept;
    logic              c1_done;
    logic [DW-1:0]     c1_dout;

    logic              mem_is_input_valid;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DW-1:0]     mem_din;
    logic              mem_ready;
    logic              mem_is_output_valid;
    logic [DW-1:0]     mem_dout;

    logic [1:0]        arb_state;

    modport slave (
        input  c0_req, c0_write, c0_addr, c0_din,
        input  c1_req, c1_write, c1_addr, c1_din,
        input  mem_ready, mem_is_output_valid, mem_dout,
        output c0_accept, c0_done, c0_dout,
        output c1_accept, c1_done, c1_dout,
        output mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din,
        output arb_state
    );

    modport master (
        output c0_req, c0_write, c0_addr, c0_din,
        output c1_req, c1_write, c1_addr, c1_din,
        output mem_ready, mem_is_output_valid, mem_dout,
        input  c0_accept, c0_done, c0_dout,
        input  c1_accept, c1_done, c1_dout,
        input  mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din,
        input  arb_state
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) block memory arbiter, one transaction in flight.
// Define ARB_FIXED_PRIO_EN for fixed priority (dcache wins ties) instead of round-robin.
module mem_arbiter #(
    parameter int LINE_SIZE = 16,
    parameter int ADDR_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int DW = LINE_SIZE * 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        WAIT_WR = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DW-1:0]     lat_din;
    logic              owner;
    logic [DW-1:0]     c0_dout_q, c1_dout_q;
    logic              c0_accept_q, c1_accept_q;
    logic              c0_done_q, c1_done_q;
    logic              take, winner, finish, capture;
    logic              tie_winner;

`ifdef ARB_FIXED_PRIO_EN
    assign tie_winner = 1'b1;
`else
    // last_grant holds the previous winner; the other client is preferred on a tie
    logic last_grant;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    last_grant <= 1'b1;
        else if (take) last_grant <= winner;
    end
    assign tie_winner = ~last_grant;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // The done cycle is spent in IDLE without arbitrating, so a client still
    // holding req while it sees done is not granted twice.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        winner    = 1'b0;
        finish    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!c0_done_q && !c1_done_q && (bus.c0_req || bus.c1_req)) begin
                    take      = 1'b1;
                    winner    = (bus.c0_req && bus.c1_req) ? tie_winner : bus.c1_req;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) state_nxt = lat_write ? WAIT_WR : WAIT_RD;
            end
            WAIT_RD: begin
                if (bus.mem_is_output_valid) begin
                    finish    = 1'b1;
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_WR: begin
                if (bus.mem_ready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_din     <= '0;
            owner       <= 1'b0;
            c0_dout_q   <= '0;
            c1_dout_q   <= '0;
            c0_accept_q <= 1'b0;
            c1_accept_q <= 1'b0;
            c0_done_q   <= 1'b0;
            c1_done_q   <= 1'b0;
        end else begin
            c0_accept_q <= take && !winner;
            c1_accept_q <= take && winner;
            c0_done_q   <= finish && !owner;
            c1_done_q   <= finish && owner;
            if (take) begin
                owner     <= winner;
                lat_write <= winner ? bus.c1_write : bus.c0_write;
                lat_addr  <= winner ? bus.c1_addr  : bus.c0_addr;
                lat_din   <= winner ? bus.c1_din   : bus.c0_din;
            end
            if (capture && !owner) c0_dout_q <= bus.mem_dout;
            if (capture && owner)  c1_dout_q <= bus.mem_dout;
        end
    end

    assign bus.c0_accept          = c0_accept_q;
    assign bus.c1_accept          = c1_accept_q;
    assign bus.c0_done            = c0_done_q;
    assign bus.c1_done            = c1_done_q;
    assign bus.c0_dout            = c0_dout_q;
    assign bus.c1_dout            = c1_dout_q;
    assign bus.mem_is_input_valid = (state == ISSUE);
    assign bus.mem_read           = (state == ISSUE) && !lat_write;
    assign bus.mem_write          = (state == ISSUE) && lat_write;
    assign bus.mem_addr           = lat_addr;
    assign bus.mem_din            = lat_din;
    assign bus.arb_state          = state;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_SIZE, default 16, is the block size in bytes; data buses are LINE_SIZE*8 bits wide (DW).
REQ-002 Parameter ADDR_W, default 32, is the width of block-shifted memory addresses.
REQ-003 The clock is clk, the only clock; reset is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- cN_req  input  1  client N (N=0 icache, N=1 dcache) request valid, held until cN_done
- cN_write  input  1  1 = block write, 0 = block read
- cN_addr  input  ADDR_W  block address
- cN_din  input  DW  write data
- cN_accept  output  1  one-cycle pulse: request latched
- cN_done  output  1  one-cycle pulse: transaction complete
- cN_dout  output  DW  read data, valid when cN_done
- mem_is_input_valid  output  1  memory request strobe
- mem_read  output  1  memory read command
- mem_write  output  1  memory write command
- mem_addr  output  ADDR_W  memory block address
- mem_din  output  DW  memory write data
- mem_ready  input  1  memory can accept a request / is idle
- mem_is_output_valid  input  1  memory read data valid
- mem_dout  input  DW  memory read data

Function
REQ-005 FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR.
REQ-006 IDLE: if any cN_req is high, select a winner, latch its write, addr and din into internal registers, pulse cN_accept for that client only, and go to ISSUE next cycle.
REQ-007 Arbitration is round-robin: a last-grant register, reset value 1, gives client 0 priority when it holds 1 and client 1 when it holds 0; it updates to the winner on each accept.
REQ-008 With a single requester, that client wins regardless of last-grant.
REQ-009 ISSUE: drive mem_is_input_valid=1 and mem_read/mem_write from the latch; mem_addr and mem_din come from the latch; hold until mem_ready=1, then go to WAIT_RD (read) or WAIT_WR (write) the next cycle.
REQ-010 The memory strobe and read/write commands are 0 in every state except ISSUE; mem_read and mem_write are never both 1.
REQ-011 WAIT_RD: on mem_is_output_valid=1, capture mem_dout into the winner's cN_dout register, pulse the winner's cN_done, and go to IDLE.
REQ-012 WAIT_WR: on the first cycle with mem_ready=1, pulse the winner's cN_done and go to IDLE.
REQ-013 cN_dout holds its last captured value until the next read completion for that client.
REQ-014 Minimum turnaround is one IDLE cycle between done and the next accept; no accept occurs in the done cycle.
REQ-015 A cN_req deasserted after accept does not abort the transaction; done is still pulsed.
REQ-016 mem_is_output_valid in any state other than WAIT_RD is ignored.

Reset
REQ-017 Asserting reset low at any time, mid-transaction included, forces: state IDLE, last-grant 1, latches 0, cN_dout 0, and all strobes, pulses and commands 0.
REQ-018 After reset is released, the first accept happens no earlier than the first rising edge with reset high; an interrupted transaction is not resumed.

Configuration
REQ-019 Macro ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority with client 1 (dcache) always winning ties and last-grant unused; when undefined, round-robin per REQ-007.

Verification
REQ-020 c0 read addr 0x10 alone, mem_ready=1, output valid 3 cycles after issue, mem_dout=0xA5..A5 -> c0_accept then mem_read=1 with mem_addr=0x10, c0_done plus c0_dout=0xA5..A5, c1 silent.
REQ-021 c0 and c1 requesting simultaneously from reset -> c0 wins first, then c1, then c0; with ARB_FIXED_PRIO_EN defined -> c1 wins every time both are requesting.
REQ-022 c1 write addr 0x3, din=0x1234, mem_ready low for 5 cycles after issue -> mem_write=1 held in ISSUE until ready, c1_done exactly on the first ready-high cycle in WAIT_WR.
REQ-023 ISSUE entered with mem_ready=0 for 4 cycles -> mem_is_input_valid held with stable addr/din and no state advance until ready.
REQ-024 reset pulled low during WAIT_RD -> all outputs 0 immediately, no cN_done; a later spurious mem_is_output_valid is ignored in IDLE.
REQ-025 Stray mem_is_output_valid during WAIT_WR -> no cN_done and no cN_dout change.
